// File: rtl/vram_arb_if.sv
// Bundle of video fetch, host access and VRAM-side signals shared by the
// arbiter (slave side) and whatever drives and observes it (master side).
interface vram_arb_if;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_rd_valid;
  logic [15:0] vid_data;

  logic        host_req;
  logic        host_wr;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic        host_rd_valid;
  logic [15:0] host_rdata;
  logic        host_stall;
  logic        stall_clr;

  logic        vram_sel;
  logic        vram_wr;
  logic [15:0] vram_addr;
  logic [15:0] vram_wdata;
  logic [15:0] vram_rdata;

  modport slave (
    input  vid_req, vid_addr,
    input  host_req, host_wr, host_addr, host_wdata, stall_clr,
    input  vram_rdata,
    output vid_rd_valid, vid_data,
    output host_ack, host_rd_valid, host_rdata, host_stall,
    output vram_sel, vram_wr, vram_addr, vram_wdata
  );

  modport master (
    output vid_req, vid_addr,
    output host_req, host_wr, host_addr, host_wdata, stall_clr,
    output vram_rdata,
    input  vid_rd_valid, vid_data,
    input  host_ack, host_rd_valid, host_rdata, host_stall,
    input  vram_sel, vram_wr, vram_addr, vram_wdata
  );
endinterface

// File: rtl/vram_arb.sv
// Two-requester VRAM arbiter: video fetch has strict priority over host
// accesses. Requests sampled at one edge are issued to VRAM (registered
// select/address) in the next cycle; read data returns one cycle later.
// A sticky stall flag reports a host that has waited too long.
module vram_arb #(
  parameter int unsigned STALL_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  vram_arb_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VID,
    S_HOST_RD,
    S_HOST_WR
  } state_t;

  localparam logic [7:0] LP_STALL_LIMIT = 8'(STALL_LIMIT);
  localparam logic [7:0] LP_WAIT_MAX    = 8'hFF;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_vram_sel;
  logic        r_vram_wr;
  logic [15:0] r_vram_addr;
  logic [15:0] r_vram_wdata;
  logic        r_vid_rd_valid;
  logic        r_host_rd_valid;
  logic [7:0]  r_wait;
  logic        r_host_stall;

  logic        w_host_ack;
  logic [7:0]  w_wait_next;
  logic        w_wait_inc;

  // The issue state itself marks the cycle in which a host access reaches VRAM.
  assign w_host_ack = (r_state == S_HOST_RD) || (r_state == S_HOST_WR);

  // Next issue decision and host wait-counter update from this cycle's requests.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a value unassigned and no latch is inferred.
    w_next_state = S_IDLE;
    w_wait_next  = r_wait;
    w_wait_inc   = 1'b0;

    if (bus.vid_req) begin
      w_next_state = S_VID;
    end else if (bus.host_req && !w_host_ack) begin
      // While ack is high the host is still holding its old request; skip it.
      w_next_state = bus.host_wr ? S_HOST_WR : S_HOST_RD;
    end

    if (!bus.host_req || w_host_ack) begin
      w_wait_next = 8'd0;
    end else if (w_next_state == S_VID && r_wait != LP_WAIT_MAX) begin
      // The host is pending but video won this slot: one more wait cycle.
      w_wait_next = r_wait + 8'd1;
      w_wait_inc  = 1'b1;
    end
  end

  // Issue state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Registered VRAM command, read-return valids, wait counter and stall flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_vram_sel      <= 1'b0;
      r_vram_wr       <= 1'b0;
      r_vram_addr     <= 16'd0;
      r_vram_wdata    <= 16'd0;
      r_vid_rd_valid  <= 1'b0;
      r_host_rd_valid <= 1'b0;
      r_wait          <= 8'd0;
      r_host_stall    <= 1'b0;
    end else begin
      r_vram_sel <= (w_next_state != S_IDLE);
      r_vram_wr  <= (w_next_state == S_HOST_WR);

      // Address and write data hold their last values while idle.
      case (w_next_state)
        S_VID: begin
          r_vram_addr <= bus.vid_addr;
        end
        S_HOST_RD, S_HOST_WR: begin
          r_vram_addr  <= bus.host_addr;
          r_vram_wdata <= bus.host_wdata;
        end
        default: begin
        end
      endcase

      // Data from the command issued this cycle arrives next cycle.
      r_vid_rd_valid  <= (r_state == S_VID);
      r_host_rd_valid <= (r_state == S_HOST_RD);

      r_wait <= w_wait_next;

      // Setting wins over a simultaneous clear.
      if (w_wait_inc && w_wait_next == LP_STALL_LIMIT) begin
        r_host_stall <= 1'b1;
      end else if (bus.stall_clr) begin
        r_host_stall <= 1'b0;
      end
    end
  end

  assign bus.vram_sel      = r_vram_sel;
  assign bus.vram_wr       = r_vram_wr;
  assign bus.vram_addr     = r_vram_addr;
  assign bus.vram_wdata    = r_vram_wdata;
  assign bus.host_ack      = w_host_ack;
  assign bus.vid_rd_valid  = r_vid_rd_valid;
  assign bus.host_rd_valid = r_host_rd_valid;
  assign bus.host_stall    = r_host_stall;

  // Read data passes straight through; the valid flags qualify it.
  assign bus.vid_data   = bus.vram_rdata;
  assign bus.host_rdata = bus.vram_rdata;

endmodule

// File: tb/tb_vram_arb.sv
// Bench for vram_arb: a behavioural 1-cycle-latency VRAM, directed stimulus
// that pushes hand-computed read data into queues, and a monitor that pops
// and compares whenever a read-valid is presented.
module tb_vram_arb;

  logic clk;
  logic reset_n;

  vram_arb_if u_if ();

  vram_arb #(.STALL_LIMIT(15)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] vid_q  [$];
  logic [15:0] host_q [$];

  int vid_valid_cnt  = 0;
  int host_valid_cnt = 0;
  int host_ack_cnt   = 0;
  int vram_wr_cnt    = 0;

  // Memory preloaded with mem[a] = a ^ 16'h5A5A.
  logic [15:0] mem [65536];

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'h5A5A;
  end

  always @(posedge clk) begin
    if (u_if.vram_sel === 1'b1) begin
      if (u_if.vram_wr === 1'b1) mem[u_if.vram_addr] <= u_if.vram_wdata;
      else                       u_if.vram_rdata     <= mem[u_if.vram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare read data against the queued expectations.
  always @(negedge clk) begin
    if (u_if.host_ack === 1'b1) host_ack_cnt++;
    if (u_if.vram_sel === 1'b1 && u_if.vram_wr === 1'b1) vram_wr_cnt++;
    if (u_if.vid_rd_valid === 1'b1) begin
      vid_valid_cnt++;
      if (vid_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL vid_unexpected: got valid data 0x%0h expected no valid at %0t", u_if.vid_data, $time);
      end else begin
        check("vid_data", 32'(u_if.vid_data), 32'(vid_q.pop_front()));
      end
    end
    if (u_if.host_rd_valid === 1'b1) begin
      host_valid_cnt++;
      if (host_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL host_unexpected: got valid data 0x%0h expected no valid at %0t", u_if.host_rdata, $time);
      end else begin
        check("host_rdata", 32'(u_if.host_rdata), 32'(host_q.pop_front()));
      end
    end
  end

  logic [15:0] exp_vid_stream [4];
  logic [15:0] exp_vid_cont   [3];

  initial begin
    exp_vid_stream = '{16'h5B5A, 16'h5B5B, 16'h5B58, 16'h5B59};  // 0x0100..0x0103
    exp_vid_cont   = '{16'h5A4A, 16'h5A4B, 16'h5A48};            // 0x0010..0x0012

    reset_n         = 1'b0;
    u_if.vid_req    = 1'b0;
    u_if.vid_addr   = 16'd0;
    u_if.host_req   = 1'b0;
    u_if.host_wr    = 1'b0;
    u_if.host_addr  = 16'd0;
    u_if.host_wdata = 16'd0;
    u_if.stall_clr  = 1'b0;
    repeat (3) step();

    // Reset state.
    check("rst_sel",        32'(u_if.vram_sel),      32'd0);
    check("rst_wr",         32'(u_if.vram_wr),       32'd0);
    check("rst_addr",       32'(u_if.vram_addr),     32'd0);
    check("rst_wdata",      32'(u_if.vram_wdata),    32'd0);
    check("rst_ack",        32'(u_if.host_ack),      32'd0);
    check("rst_vid_valid",  32'(u_if.vid_rd_valid),  32'd0);
    check("rst_host_valid", 32'(u_if.host_rd_valid), 32'd0);
    check("rst_stall",      32'(u_if.host_stall),    32'd0);

    // Video-only stream, starting in the first cycle after reset release.
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      u_if.vid_req  = 1'b1;
      u_if.vid_addr = 16'h0100 + 16'(i);
      vid_q.push_back(exp_vid_stream[i]);
      step();
      check("vid_sel",  32'(u_if.vram_sel),  32'd1);
      check("vid_wr",   32'(u_if.vram_wr),   32'd0);
      check("vid_addr", 32'(u_if.vram_addr), 32'h0100 + 32'(i));
    end
    u_if.vid_req = 1'b0;
    step();
    check("idle_sel",       32'(u_if.vram_sel),     32'd0);
    check("idle_addr_hold", 32'(u_if.vram_addr),    32'h0103);
    check("vid_last_valid", 32'(u_if.vid_rd_valid), 32'd1);
    step();
    check("vid_stream_end", 32'(u_if.vid_rd_valid), 32'd0);

    // Host write 0x1234 to 0xC000, then read it back.
    u_if.host_req   = 1'b1;
    u_if.host_wr    = 1'b1;
    u_if.host_addr  = 16'hC000;
    u_if.host_wdata = 16'h1234;
    step();
    check("hw_ack",   32'(u_if.host_ack),   32'd1);
    check("hw_wr",    32'(u_if.vram_wr),    32'd1);
    check("hw_addr",  32'(u_if.vram_addr),  32'hC000);
    check("hw_wdata", 32'(u_if.vram_wdata), 32'h1234);
    u_if.host_wr = 1'b0;
    host_q.push_back(16'h1234);
    step();
    check("hr_ack_ignored", 32'(u_if.host_ack), 32'd0);
    check("hr_gap_sel",     32'(u_if.vram_sel), 32'd0);
    step();
    check("hr_ack",  32'(u_if.host_ack), 32'd1);
    check("hr_wr",   32'(u_if.vram_wr),  32'd0);
    u_if.host_req = 1'b0;
    step();
    check("hr_valid", 32'(u_if.host_rd_valid), 32'd1);
    step();
    check("hr_valid_once", 32'(u_if.host_rd_valid), 32'd0);

    // Contention: video wins three slots, host read of 0x4000 follows.
    u_if.host_req  = 1'b1;
    u_if.host_wr   = 1'b0;
    u_if.host_addr = 16'h4000;
    host_q.push_back(16'h1A5A);
    for (int i = 0; i < 3; i++) begin
      u_if.vid_req  = 1'b1;
      u_if.vid_addr = 16'h0010 + 16'(i);
      vid_q.push_back(exp_vid_cont[i]);
      step();
      check("cont_vid_addr", 32'(u_if.vram_addr), 32'h0010 + 32'(i));
      check("cont_no_ack",   32'(u_if.host_ack),  32'd0);
    end
    u_if.vid_req = 1'b0;
    step();
    check("cont_ack",  32'(u_if.host_ack),  32'd1);
    check("cont_addr", 32'(u_if.vram_addr), 32'h4000);
    u_if.host_req = 1'b0;
    step();
    check("cont_valid", 32'(u_if.host_rd_valid), 32'd1);
    step();

    // Starvation: video held 20 cycles while host read of 0x0030 waits.
    u_if.host_req  = 1'b1;
    u_if.host_wr   = 1'b0;
    u_if.host_addr = 16'h0030;
    u_if.vid_req   = 1'b1;
    u_if.vid_addr  = 16'h0020;
    host_q.push_back(16'h5A6A);
    for (int k = 0; k < 20; k++) begin
      vid_q.push_back(16'h5A7A);
      step();
      check("starve_stall", 32'(u_if.host_stall), 32'((k + 1) >= 15));
    end
    u_if.vid_req = 1'b0;
    step();
    check("starve_ack", 32'(u_if.host_ack), 32'd1);
    u_if.host_req = 1'b0;
    step();
    check("starve_valid",  32'(u_if.host_rd_valid), 32'd1);
    check("stall_sticky",  32'(u_if.host_stall),    32'd1);
    u_if.stall_clr = 1'b1;
    step();
    check("stall_cleared", 32'(u_if.host_stall), 32'd0);
    u_if.stall_clr = 1'b0;
    step();
    check("stall_stays_clear", 32'(u_if.host_stall), 32'd0);

    // Reset while a video read is in flight: its valid must not appear.
    u_if.vid_req  = 1'b1;
    u_if.vid_addr = 16'h0040;
    step();
    check("rv_sel", 32'(u_if.vram_sel), 32'd1);
    reset_n      = 1'b0;
    u_if.vid_req = 1'b0;
    step();
    check("rv_valid_dropped", 32'(u_if.vid_rd_valid), 32'd0);
    reset_n = 1'b1;
    step();

    // Reset in the cycle a host write is issued.
    u_if.host_req   = 1'b1;
    u_if.host_wr    = 1'b1;
    u_if.host_addr  = 16'h5555;
    u_if.host_wdata = 16'hBEEF;
    step();
    check("rw_ack", 32'(u_if.host_ack), 32'd1);
    check("rw_wr",  32'(u_if.vram_wr),  32'd1);
    reset_n       = 1'b0;
    u_if.host_req = 1'b0;
    step();
    check("rw_sel",   32'(u_if.vram_sel),   32'd0);
    check("rw_wr0",   32'(u_if.vram_wr),    32'd0);
    check("rw_addr",  32'(u_if.vram_addr),  32'd0);
    check("rw_wdata", 32'(u_if.vram_wdata), 32'd0);
    check("rw_ack0",  32'(u_if.host_ack),   32'd0);
    reset_n = 1'b1;
    step();
    check("rw_post_wr",  32'(u_if.vram_wr),  32'd0);
    check("rw_post_sel", 32'(u_if.vram_sel), 32'd0);
    repeat (2) step();
    check("rw_no_ack",   32'(u_if.host_ack),      32'd0);
    check("rw_no_valid", 32'(u_if.host_rd_valid), 32'd0);

    // Drain and totals.
    for (int t = 0; t < 20 && (vid_q.size() != 0 || host_q.size() != 0); t++) step();
    step();
    check("vid_q_empty",    32'(vid_q.size()),   32'd0);
    check("host_q_empty",   32'(host_q.size()),  32'd0);
    check("vid_valid_cnt",  32'(vid_valid_cnt),  32'd27);
    check("host_valid_cnt", 32'(host_valid_cnt), 32'd3);
    check("host_ack_cnt",   32'(host_ack_cnt),   32'd5);
    check("vram_wr_cnt",    32'(vram_wr_cnt),    32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 Parameter: STALL_LIMIT, default 15, host wait-cycle count at which host_stall is set (range 1..255).
REQ-002 clk  in  1  single system clock; all logic on rising edge.
REQ-003 reset_n  in  1  reset; synchronous and active-low.
REQ-004 vid_req  in  1  video fetch read request, one word per asserted cycle.
REQ-005 vid_addr  in  16  video fetch word address.
REQ-006 vid_rd_valid  out  1  vid_data valid this cycle.
REQ-007 vid_data  out  16  video read data.
REQ-008 host_req  in  1  host access request; held with stable addr/wr/wdata until host_ack.
REQ-009 host_wr  in  1  1 = write, 0 = read.
REQ-010 host_addr  in  16  host word address.
REQ-011 host_wdata  in  16  host write data.
REQ-012 host_ack  out  1  one-cycle pulse: host access issued to VRAM this cycle.
REQ-013 host_rd_valid  out  1  host_rdata valid this cycle.
REQ-014 host_rdata  out  16  host read data.
REQ-015 host_stall  out  1  sticky: host waited >= STALL_LIMIT cycles.
REQ-016 stall_clr  in  1  clears host_stall.
REQ-017 vram_sel  out  1  VRAM select, registered.
REQ-018 vram_wr  out  1  VRAM write enable, registered.
REQ-019 vram_addr  out  16  VRAM address, registered.
REQ-020 vram_wdata  out  16  VRAM write data, registered.
REQ-021 vram_rdata  in  16  VRAM read data; valid the cycle after a select with 1-cycle read latency.

Function
REQ-022 Issue state register, one of IDLE, VID, HOST_RD, HOST_WR, updated every cycle from requests sampled in the previous cycle.
REQ-023 Priority: vid_req sampled high -> VID, regardless of host_req.
REQ-024 Else host_req high and host_ack low -> HOST_WR if host_wr else HOST_RD; else IDLE.
REQ-025 host_req SHALL be ignored in any cycle where host_ack is high (no double issue).
REQ-026 Request sampled at cycle N -> vram_sel/vram_addr driven in cycle N+1; read data presented in cycle N+2.
REQ-027 VID: vram_sel=1, vram_wr=0, vram_addr=vid_addr captured at N.
REQ-028 HOST_RD/HOST_WR: vram_sel=1, vram_wr=host_wr, vram_addr=host_addr, vram_wdata=host_wdata (captured at N); host_ack=1 in N+1.
REQ-029 IDLE: vram_sel=0, vram_wr=0; vram_addr/vram_wdata hold previous values.
REQ-030 vid_rd_valid=1 in cycle N+2 for each VID issue; host_rd_valid=1 in N+2 for each HOST_RD; never for HOST_WR.
REQ-031 vid_data and host_rdata SHALL equal vram_rdata combinationally (both always, qualified only by their valid flags).
REQ-032 Back-to-back: consecutive vid_req cycles yield consecutive issues and consecutive vid_rd_valid cycles, no bubbles.
REQ-033 Wait counter: 8-bit; increments each cycle host_req high, host_ack low and not issued; resets to 0 on host_ack or host_req low; saturates at 255.
REQ-034 host_stall set when wait counter == STALL_LIMIT; cleared by stall_clr; set takes priority if both occur in the same cycle.
REQ-035 A write issued in N+1 followed by a read of the same address at N+2 SHALL return the written data.

Reset
REQ-036 reset_n low at a rising edge: state IDLE, vram_sel=0, vram_wr=0, vram_addr=0, vram_wdata=0, host_ack=0, vid_rd_valid=0, host_rd_valid=0, wait counter=0, host_stall=0.
REQ-037 Reset mid-operation drops all pending valids and acks in the next cycle; no VRAM write may occur during reset or in the cycle following its release.
REQ-038 Requests present in the first cycle after release are sampled normally.

Verification
REQ-039 Video-only stream: vid_req high 4 cycles, addr 0x0100..0x0103 -> vram_sel high 4 cycles from N+1; vid_rd_valid 4 cycles from N+2 returning memory contents in order.
REQ-040 Host write then read: write 0x1234 to 0xC000, ack, then read 0xC000 -> host_ack pulses each access; host_rd_valid once, host_rdata=0x1234; vram_wr high exactly 1 cycle.
REQ-041 Contention: vid_req and host_req (read 0x4000) both high 3 cycles -> 3 VID issues first; host_ack in the cycle after vid_req drops; host_rd_valid the next cycle.
REQ-042 Starvation: vid_req held 20 cycles with host_req pending, STALL_LIMIT=15 -> host_stall rises on the 15th wait cycle, stays high; stall_clr pulse afterwards clears it.
REQ-043 Reset mid-access: reset_n low in the cycle a HOST_WR is issued -> outputs all 0 next cycle; no host_ack or valid afterwards until a new request.
